tm1638_display_ctrl: RTL and testbench
======================================

TM1638_DISPLAY_CTRL -- requirements
Module: tm1638_display_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clock cycles per half-period of tm_clk (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-004 SHALL have port update, input, 1, a one-cycle request to refresh the display.
REQ-005 SHALL have port hex_value, input, 32, eight hex digits; nibble [31:28] is the leftmost digit.
REQ-006 SHALL have port dots, input, 8, decimal points; bit 7 is the leftmost digit.
REQ-007 SHALL have port leds, input, 8, discrete LEDs; bit 7 is the leftmost LED.
REQ-008 SHALL have port brightness, input, 3, PWM level 0..7.
REQ-009 SHALL have port display_on, input, 1, display enable.
REQ-010 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse at the end of each frame.
REQ-012 SHALL have ports tm_stb, tm_clk and tm_dio, outputs, 1 bit each, the TM1638 strobe, clock and data (write-only, no readback).

Function
REQ-013 SHALL, when idle and update=1, snapshot all data inputs in that cycle, assert busy the next cycle and start a frame.
REQ-014 SHALL hold a single pending flag when update=1 arrives while busy; further updates merge into that flag.
REQ-015 SHALL, when the pending flag is set at frame end, re-snapshot the inputs and start a new frame after the final gap, with busy staying high.
REQ-016 SHALL send each frame as three strobe groups:
  - group 1: {0x40}
  - group 2: {0xC0, D0..D15}
  - group 3: {0x80 | display_on<<3 | brightness}
REQ-017 SHALL form the data bytes, for position p = 0..7 (left to right), as:
  - D(2p) = bin2led7(hex_value[31-4p -: 4]) with bit 7 replaced by dots[7-p]
  - D(2p+1) = {7'b0, leds[7-p]}
REQ-018 SHALL run each group as follows:
  - tm_stb falls, then CLK_DIV cycles of setup;
  - bytes are sent back to back;
  - tm_stb rises one cycle after the last bit's high phase ends;
  - tm_stb then stays high for 2*CLK_DIV cycles (gap).
REQ-019 SHALL send bytes LSB first; per bit, tm_dio changes with the tm_clk falling edge, tm_clk is low for CLK_DIV cycles then high for CLK_DIV cycles (data is sampled on the rising edge).
REQ-020 SHALL take exactly 16*CLK_DIV cycles per byte and 313*CLK_DIV cycles per frame, measured from the first busy cycle to the last.
REQ-021 SHALL pulse done and drop busy in the cycle after the final gap, unless a pending frame follows; in that case done still pulses and busy stays high.
REQ-022 SHALL implement the FSM states IDLE, SETUP, SEND, GAP, FINISH, with these transitions:
  - IDLE→SETUP on update;
  - SETUP→SEND;
  - SEND→SEND between bytes of a group;
  - SEND→GAP on the last byte of a group;
  - GAP→SETUP for groups 2 and 3;
  - GAP→FINISH after group 3;
  - FINISH→SETUP if pending, else FINISH→IDLE.
REQ-023 SHALL not let input changes during a frame affect that frame.
REQ-024 SHALL hold tm_clk=1, tm_stb=1 and tm_dio=0 in IDLE.

Reset
REQ-025 SHALL, while rst=1, immediately force: tm_stb=1, tm_clk=1, tm_dio=0, busy=0, done=0, pending=0, state=IDLE, and all counters to 0.
REQ-026 SHALL, when rst is asserted mid-frame, abort the frame with no done pulse, and accept update again in the first cycle after rst deasserts.

Structure
REQ-027 SHALL take digit encoding from bin2led7 in the existing led7_types package.
REQ-028 SHALL place the TM1638 command constants (0x40, 0xC0, 0x80) and the state enum in a new shared package, tm1638_types.
REQ-029 SHALL instantiate one sub-module, tm1638_byte_tx, with:
  - a byte in plus valid/ready handshake, where ready is high when the shifter is idle;
  - the tm_clk and tm_dio outputs;
  - parameter CLK_DIV.
  The controller owns tm_stb and sequencing.

Verification
REQ-030 SHALL cover: CLK_DIV=2, hex_value=0x0123ABCD, dots=0, leds=0x01, brightness=7, display_on=1, update -> bytes 40 | C0 3F 00 06 00 5B 00 4F 00 77 00 7C 00 39 00 5E 01 | 8F; done 626 cycles after busy rises.
REQ-031 SHALL cover: dots=0x80, hex_value=0x80000000, display_on=0, brightness=2 -> D0=0xFF, control byte 0x82.
REQ-032 SHALL cover: update pulsed 3 times during a frame with hex_value changed to 0xFFFFFFFF -> exactly one extra frame with D even = 0x71, two done pulses total, busy continuous.
REQ-033 SHALL cover: rst asserted at cycle 100 of a frame -> tm_stb=1 and tm_clk=1 in the same cycle, no done; a new update then gives a full, correct frame.
REQ-034 SHALL cover: a protocol checker on every bit (CLK_DIV=1 and 4) -> tm_dio stable through each high phase, tm_stb low >= CLK_DIV cycles before the first falling edge, and high-gap = 2*CLK_DIV.

Source files
------------

// File: rtl/led7_types.sv
// Seven-segment digit encoding shared by display drivers.
// Segment order is {dp, g, f, e, d, c, b, a}. The decimal point (bit 7) is always off here.
package led7_types;

  function automatic logic [7:0] bin2led7(input logic [3:0] value);
    logic [7:0] seg;
    unique case (value)
      4'h0: seg = 8'h3f;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5b;
      4'h3: seg = 8'h4f;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6d;
      4'h6: seg = 8'h7d;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7f;
      4'h9: seg = 8'h6f;
      4'ha: seg = 8'h77;
      4'hb: seg = 8'h7c;
      4'hc: seg = 8'h39;
      4'hd: seg = 8'h5e;
      4'he: seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tm1638_types.sv
// Shared TM1638 command bytes, controller state codes and the frame byte builder.
package tm1638_types;
  import led7_types::*;

  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;  // write data, auto-increment address
  localparam logic [7:0] CMD_ADDR_0    = 8'hc0;  // set address 0
  localparam logic [7:0] CMD_DISPLAY   = 8'h80;  // display control

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_SEND   = 3'd2;
  localparam state_t ST_GAP    = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // Index of the last byte in the address+data group (address byte plus 16 data bytes).
  localparam logic [4:0] GRP2_LAST_IDX = 5'd16;

  typedef struct packed {
    logic [31:0] hex;
    logic [7:0]  dots;
    logic [7:0]  leds;
    logic [2:0]  bright;
    logic        disp_on;
  } frame_t;

  // Byte idx of group grp. In group 1, odd idx carries a digit and even idx (>0) an LED.
  function automatic logic [7:0] frame_byte(input logic [1:0] grp, input logic [4:0] idx,
                                            input frame_t f);
    logic [7:0] b;
    logic [2:0] p;
    logic [3:0] nib;
    logic [7:0] seg;
    p   = 3'((idx - 5'd1) >> 1);
    nib = f.hex[{~p, 2'b00} +: 4];
    seg = bin2led7(nib);
    unique case (grp)
      2'd0: b = CMD_DATA_AUTO;
      2'd1: begin
        if (idx == 5'd0) begin
          b = CMD_ADDR_0;
        end else if (idx[0]) begin
          b = {f.dots[~p], seg[6:0]};
        end else begin
          b = {7'b0, f.leds[~p]};
        end
      end
      default: b = CMD_DISPLAY | {4'b0, f.disp_on, f.bright};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tm1638_byte_tx.sv
// LSB-first byte shifter for the TM1638 clock/data pair; 16*CLK_DIV cycles per byte.
module tm1638_byte_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tm_clk,
  output logic       tm_dio
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic       active_q;
  logic [6:0] shift_q;
  logic [2:0] bit_q;
  logic [7:0] div_q;
  logic       tm_clk_q;
  logic       tm_dio_q;
  logic       last_cycle;

  // Ready also in the final high cycle so the next byte follows with no idle cycle.
  assign last_cycle = active_q && tm_clk_q && (div_q == DIV_LAST) && (bit_q == 3'd7);
  assign ready      = !active_q || last_cycle;
  assign tm_clk     = tm_clk_q;
  assign tm_dio     = tm_dio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      tm_clk_q <= 1'b1;
      tm_dio_q <= 1'b0;
    end else if (valid && ready) begin
      active_q <= 1'b1;
      shift_q  <= data[7:1];
      tm_dio_q <= data[0];
      tm_clk_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
    end else if (active_q) begin
      if (div_q != DIV_LAST) begin
        div_q <= div_q + 8'd1;
      end else begin
        div_q <= '0;
        if (!tm_clk_q) begin
          tm_clk_q <= 1'b1;
        end else if (bit_q == 3'd7) begin
          active_q <= 1'b0;
          tm_dio_q <= 1'b0;
        end else begin
          tm_clk_q <= 1'b0;
          bit_q    <= bit_q + 3'd1;
          tm_dio_q <= shift_q[0];
          shift_q  <= {1'b0, shift_q[6:1]};
        end
      end
    end
  end

endmodule

// File: rtl/tm1638_display_ctrl.sv
// TM1638 frame sequencer: snapshots the display inputs and sends the three strobe groups.
module tm1638_display_ctrl
  import tm1638_types::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [31:0] hex_value,
  input  logic [7:0]  dots,
  input  logic [7:0]  leds,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  output logic        busy,
  output logic        done,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio
);
  localparam logic [8:0] SETUP_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);

  state_t     st_q, st_d;
  logic [8:0] cnt_q, cnt_d;
  logic [1:0] grp_q, grp_d;
  logic [4:0] idx_q, idx_d;
  logic       pend_q, pend_d;
  frame_t     frame_q;
  logic       snap_en;
  logic       in_frame;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] tx_idx;
  logic [7:0] tx_data;
  logic [4:0] last_idx;

  assign last_idx = (grp_q == 2'd1) ? GRP2_LAST_IDX : 5'd0;
  assign in_frame = (st_q == ST_SETUP) || (st_q == ST_SEND) || (st_q == ST_GAP);
  assign tx_data  = frame_byte(grp_q, tx_idx, frame_q);

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    grp_d    = grp_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    snap_en  = 1'b0;
    tx_valid = 1'b0;
    tx_idx   = idx_q + 5'd1;
    unique case (st_q)
      ST_IDLE: begin
        if (update) begin
          snap_en = 1'b1;
          st_d    = ST_SETUP;
          cnt_d   = '0;
          grp_d   = '0;
        end
      end
      ST_SETUP: begin
        tx_idx = 5'd0;
        if (cnt_q == SETUP_LAST) begin
          tx_valid = 1'b1;
          idx_d    = 5'd0;
          cnt_d    = '0;
          st_d     = ST_SEND;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_SEND: begin
        // tx_ready here marks the last cycle of the byte in flight.
        if (tx_ready) begin
          if (idx_q != last_idx) begin
            tx_valid = 1'b1;
            idx_d    = idx_q + 5'd1;
          end else begin
            cnt_d = '0;
            st_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (grp_q == 2'd2) begin
            st_d = ST_FINISH;
          end else begin
            grp_d = grp_q + 2'd1;
            st_d  = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_FINISH: begin
        // busy is already low here unless pending, so a fresh update is honoured too.
        pend_d = 1'b0;
        if (pend_q || update) begin
          snap_en = 1'b1;
          st_d    = ST_SETUP;
          cnt_d   = '0;
          grp_d   = '0;
        end else begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (update && in_frame) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      grp_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      grp_q  <= grp_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      if (snap_en) begin
        frame_q <= '{hex: hex_value, dots: dots, leds: leds, bright: brightness,
                     disp_on: display_on};
      end
    end
  end

  assign busy   = (st_q != ST_IDLE) && !((st_q == ST_FINISH) && !pend_q);
  assign done   = (st_q == ST_FINISH);
  assign tm_stb = !((st_q == ST_SETUP) || (st_q == ST_SEND));

  tm1638_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_byte_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (tx_valid),
    .data  (tx_data),
    .ready (tx_ready),
    .tm_clk(tm_clk),
    .tm_dio(tm_dio)
  );

endmodule

// File: tb/tb_tm1638_display_ctrl.sv
// Drives three controllers (CLK_DIV 2, 1, 4) with shared stimulus; bus monitors decode
// the TM1638 stream per instance and compare it against a queue of expected bytes.
module tb_tm1638_display_ctrl;
  localparam int NDUT = 3;

  function automatic int cd_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  localparam logic [7:0] SEG [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                                      8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71};

  typedef struct packed {
    logic       first;
    logic [7:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        update;
  logic [31:0] hex_value;
  logic [7:0]  dots;
  logic [7:0]  leds;
  logic [2:0]  brightness;
  logic        display_on;
  logic [NDUT-1:0] busy_w, done_w, stb_w, tclk_w, dio_w;

  exp_t exp_q [NDUT][$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt [NDUT];
  int   fall_cnt [NDUT];
  int   done0 [NDUT];
  int   fall0 [NDUT];

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int CD = cd_of(gi);

    tm1638_display_ctrl #(
      .CLK_DIV(CD)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .update    (update),
      .hex_value (hex_value),
      .dots      (dots),
      .leds      (leds),
      .brightness(brightness),
      .display_on(display_on),
      .busy      (busy_w[gi]),
      .done      (done_w[gi]),
      .tm_stb    (stb_w[gi]),
      .tm_clk    (tclk_w[gi]),
      .tm_dio    (dio_w[gi])
    );

    logic       s, c, d, pstb, pclk, pbusy, dio_hi, hi_ok, fell_yet, first;
    logic [7:0] sh;
    int         nbit, pre, hi_run, ngrp, fcnt;
    exp_t       e;

    always @(negedge clk) begin
      if (rst) begin
        pstb = 1'b1; pclk = 1'b1; pbusy = 1'b0; dio_hi = 1'b0; hi_ok = 1'b1;
        fell_yet = 1'b0; first = 1'b0; sh = '0;
        nbit = 0; pre = 0; hi_run = 0; ngrp = 0; fcnt = 0;
      end else begin
        s = stb_w[gi]; c = tclk_w[gi]; d = dio_w[gi];
        if (pstb && !s) begin
          if (ngrp != 0) check($sformatf("cd%0d inter-group gap", CD), hi_run, 2 * CD);
          ngrp++; nbit = 0; first = 1'b1; pre = 1; fell_yet = 1'b0;
        end else if (!s && !fell_yet && c) begin
          pre++;
        end
        if (!s && pclk && !c) begin
          if (!fell_yet) begin
            check($sformatf("cd%0d strobe setup", CD), pre, CD);
            fell_yet = 1'b1;
          end else begin
            check($sformatf("cd%0d dio stable in high phase", CD), int'(hi_ok), 1);
          end
        end
        if (!s && !pclk && c) begin
          sh[nbit[2:0]] = d; dio_hi = d; hi_ok = 1'b1; nbit++;
          if (nbit == 8) begin
            if (exp_q[gi].size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL cd%0d byte: got 0x%02h, expected no byte", CD, sh);
            end else begin
              e = exp_q[gi].pop_front();
              check($sformatf("cd%0d byte {first,data}", CD), int'({first, sh}),
                    int'({e.first, e.b}));
            end
            nbit = 0; first = 1'b0;
          end
        end else if (!s && c && pclk && fell_yet && (d !== dio_hi)) begin
          hi_ok = 1'b0;
        end
        if (!pstb && s) begin
          check($sformatf("cd%0d strobe rise on byte boundary", CD), nbit, 0);
          check($sformatf("cd%0d dio stable in last high phase", CD), int'(hi_ok), 1);
          hi_run = 1;
        end else if (s) begin
          hi_run++;
        end
        if (done_w[gi]) begin
          check($sformatf("cd%0d final gap", CD), hi_run, 2 * CD + 1);
          check($sformatf("cd%0d frame length", CD), fcnt, 313 * CD);
          check($sformatf("cd%0d groups per frame", CD), ngrp, 3);
          done_cnt[gi]++; fcnt = 0; ngrp = 0;
        end else if (busy_w[gi]) begin
          fcnt++;
        end else begin
          fcnt = 0;
        end
        if (pbusy && !busy_w[gi]) fall_cnt[gi]++;
        pstb = s; pclk = c; pbusy = busy_w[gi];
      end
    end
  end

  // Reference frame built straight from the command/data byte rules.
  task automatic push_frame(input logic [31:0] hv, input logic [7:0] dt, input logic [7:0] ld,
                            input logic [2:0] br, input logic dsp);
    logic [7:0] bytes [19];
    bytes[0] = 8'h40;
    bytes[1] = 8'hc0;
    for (int p = 0; p < 8; p++) begin
      int digit;
      digit = int'((hv >> (28 - 4 * p)) & 32'hf);
      bytes[2 + 2 * p] = SEG[digit] | (dt[7 - p] ? 8'h80 : 8'h00);
      bytes[3 + 2 * p] = {7'd0, ld[7 - p]};
    end
    bytes[18] = 8'h80 + (dsp ? 8'd8 : 8'd0) + 8'(br);
    for (int i = 0; i < NDUT; i++) begin
      for (int j = 0; j < 19; j++) begin
        exp_q[i].push_back('{first: (j == 0 || j == 1 || j == 18), b: bytes[j]});
      end
    end
  endtask

  task automatic randomize_inputs();
    hex_value  = $urandom;
    dots       = 8'($urandom);
    leds       = 8'($urandom);
    brightness = 3'($urandom);
    display_on = 1'($urandom);
  endtask

  task automatic snap_counts();
    for (int i = 0; i < NDUT; i++) begin
      done0[i] = done_cnt[i];
      fall0[i] = fall_cnt[i];
    end
  endtask

  // Called at posedge+1; update is sampled at the following edge.
  task automatic start_frame(input string tag);
    check($sformatf("%s busy before update", tag), int'(busy_w), 0);
    push_frame(hex_value, dots, leds, brightness, display_on);
    update = 1'b1;
    @(posedge clk);
    #1 update = 1'b0;
    check($sformatf("%s busy after update", tag), int'(busy_w), 7);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_w != '0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s finished within budget", tag), int'(n < budget), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic end_scenario(input string tag, input int exp_done, input int exp_fall);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s dut%0d leftover bytes", tag, i), exp_q[i].size(), 0);
      check($sformatf("%s dut%0d done pulses", tag, i), done_cnt[i] - done0[i], exp_done);
      check($sformatf("%s dut%0d busy drops", tag, i), fall_cnt[i] - fall0[i], exp_fall);
      check($sformatf("%s dut%0d idle pins stb/clk/dio/done", tag, i),
            int'({stb_w[i], tclk_w[i], dio_w[i], done_w[i]}), 4'b1100);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; update = 1'b0;
    hex_value = '0; dots = '0; leds = '0; brightness = '0; display_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("reset dut%0d stb/clk/dio/busy/done", i),
            int'({stb_w[i], tclk_w[i], dio_w[i], busy_w[i], done_w[i]}), 5'b11000);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    snap_counts();
    hex_value = 32'h0123abcd; dots = 8'h00; leds = 8'h01; brightness = 3'd7; display_on = 1'b1;
    start_frame("fixed");
    wait_idle("fixed", 3000);
    end_scenario("fixed", 1, 1);

    snap_counts();
    hex_value = 32'h80000000; dots = 8'h80; leds = 8'h00; brightness = 3'd2; display_on = 1'b0;
    start_frame("dots");
    wait_idle("dots", 3000);
    end_scenario("dots", 1, 1);

    // Inputs are scrambled mid-frame; the snapshot taken at update must still be sent.
    for (int k = 0; k < 5; k++) begin
      snap_counts();
      randomize_inputs();
      start_frame("rand");
      repeat (10 + $urandom_range(0, 50)) @(posedge clk);
      #1 randomize_inputs();
      wait_idle("rand", 3000);
      end_scenario("rand", 1, 1);
    end

    snap_counts();
    randomize_inputs();
    start_frame("pend");
    repeat (20) @(posedge clk);
    #1;
    hex_value = 32'hffffffff; dots = 8'h00; leds = 8'($urandom);
    brightness = 3'($urandom); display_on = 1'($urandom);
    push_frame(hex_value, dots, leds, brightness, display_on);
    for (int k = 0; k < 3; k++) begin
      repeat (15) @(posedge clk);
      #1 update = 1'b1;
      @(posedge clk);
      #1 update = 1'b0;
    end
    wait_idle("pend", 6000);
    end_scenario("pend", 2, 1);

    snap_counts();
    randomize_inputs();
    start_frame("abort");
    repeat (99) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("abort dut%0d stb/clk/busy/done", i),
            int'({stb_w[i], tclk_w[i], busy_w[i], done_w[i]}), 4'b1100);
      exp_q[i].delete();
    end
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort no done pulse", int'(done_w), 0);
    randomize_inputs();
    start_frame("after reset");
    wait_idle("after reset", 3000);
    end_scenario("after reset", 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
